// File: rtl/seg_scan_driver_pkg.sv
// Shared glyph constants and leading-zero helper for the 7-segment scan driver.
// All glyphs are active-low, bit order gfedcba.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_B    = 7'b0000011;
  localparam logic [6:0] SEG_C    = 7'b1000110;
  localparam logic [6:0] SEG_D    = 7'b0100001;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_F    = 7'b0001110;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Upper bound on display width handled by the helper below.
  localparam int MAX_DIGITS = 32;

  // Leading-zero suppression mask: bit i set when digit i and every digit
  // above it carry code 0 with no decimal point. Digit 0 is never set.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] bcd,
    input logic [MAX_DIGITS-1:0]   dp,
    input int                      n_digits
  );
    logic                  run;
    logic [MAX_DIGITS-1:0] m;
    m   = '0;
    run = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < n_digits) begin
        run  = run & (bcd[4*i +: 4] == 4'd0) & ~dp[i];
        m[i] = run;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_driver_decode.sv
// Combinational 4-bit code to active-low 7-segment glyph decoder.
module seg_decode
  import seg_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Glyph lookup; codes above 9 become hex letters or a dash.
  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = (HEX_MODE != 0) ? SEG_A : SEG_DASH;
      4'hB: seg = (HEX_MODE != 0) ? SEG_B : SEG_DASH;
      4'hC: seg = (HEX_MODE != 0) ? SEG_C : SEG_DASH;
      4'hD: seg = (HEX_MODE != 0) ? SEG_D : SEG_DASH;
      4'hE: seg = (HEX_MODE != 0) ? SEG_E : SEG_DASH;
      4'hF: seg = (HEX_MODE != 0) ? SEG_F : SEG_DASH;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with blanking slot,
// leading-zero suppression, per-digit decimal point and per-digit blink.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_LOG2 = 5,
  parameter int HEX_MODE   = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  En,
  input  logic                  Load,
  input  logic [4*N_DIGITS-1:0] Bcd,
  input  logic [N_DIGITS-1:0]   Dp,
  input  logic [N_DIGITS-1:0]   Blink_mask,
  input  logic                  Blank_lz,
  output logic [6:0]            Seg,
  output logic                  Dp_n,
  output logic [N_DIGITS-1:0]   An
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int FRM_W = (BLINK_LOG2 < 1) ? 1 : BLINK_LOG2;
  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam logic [N_DIGITS-1:0] AN_ONE = 1;

  logic [4*N_DIGITS-1:0]        bcd_q;
  logic [N_DIGITS-1:0]          dp_q;
  logic [N_DIGITS-1:0]          blink_q;
  logic                         blz_q;

  logic [CNT_W-1:0]             cnt;
  logic [IDX_W-1:0]             idx;
  logic                         blank;
  logic [FRM_W-1:0]             frm_cnt;
  logic                         phase;

  logic                         slot_end;
  logic                         idx_last;
  logic                         frm_wrap;
  logic [N_DIGITS-1:0]          supp;
  logic [N_DIGITS-1:0][6:0]     glyph;
  logic                         lit;
  logic [6:0]                   seg_nxt;
  logic                         dp_n_nxt;
  logic [N_DIGITS-1:0]          an_nxt;

  assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_last = (idx == IDX_W'(N_DIGITS - 1));
  assign frm_wrap = (BLINK_LOG2 == 0) || (frm_cnt == '1);

  // Latch the display word on the load strobe.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bcd_q   <= '0;
      dp_q    <= '0;
      blink_q <= '0;
      blz_q   <= 1'b0;
    end else if (Load) begin
      bcd_q   <= Bcd;
      dp_q    <= Dp;
      blink_q <= Blink_mask;
      blz_q   <= Blank_lz;
    end
  end

  // Slot timer, digit index, frame counter and blink phase.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      blank   <= 1'b0;
      frm_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      blank <= slot_end;
      if (slot_end) begin
        cnt <= '0;
        if (idx_last) begin
          idx     <= '0;
          frm_cnt <= frm_cnt + FRM_W'(1);
          if (frm_wrap) phase <= ~phase;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // One decoder per digit; the scan index selects which glyph reaches the pins.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg_decode #(.HEX_MODE(HEX_MODE)) u_dec (
      .code (bcd_q[4*g +: 4]),
      .seg  (glyph[g])
    );
  end

  assign supp = N_DIGITS'(lz_mask(BCD_W'(bcd_q), MAX_DIGITS'(dp_q), N_DIGITS))
                & {N_DIGITS{blz_q}};

  assign lit = En && !blank && !(blink_q[idx] && phase) && !supp[idx];

  // Next pin values: the selected digit when lit, all-off otherwise.
  always_comb begin
    seg_nxt  = SEG_OFF;
    dp_n_nxt = 1'b1;
    an_nxt   = '1;
    if (lit) begin
      seg_nxt  = glyph[idx];
      dp_n_nxt = ~dp_q[idx];
      an_nxt   = ~(AN_ONE << idx);
    end
  end

  // Registered pins, one cycle behind the scan index.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Seg  <= SEG_OFF;
      Dp_n <= 1'b1;
      An   <= '1;
    end else begin
      Seg  <= seg_nxt;
      Dp_n <= dp_n_nxt;
      An   <= an_nxt;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Multiplexed N-digit 7-segment display driver; generalises the single-digit BCD decoder to a time-scanned multi-digit display.
- Latches a packed BCD/hex word, then cycles the common-anode enables one digit at a time.
- Adds:
  - a blanking cycle between digits (anti-ghosting)
  - leading-zero suppression
  - per-digit decimal points
  - per-digit blink
- Sits between counter/datapath logic and the board display pins.

Parameters:
N_DIGITS, 4, number of digits (>=2); digit 0 is least significant (rightmost).
SCAN_DIV, 50000, clock cycles per digit slot (>=2).
BLINK_LOG2, 5, blink phase toggles every 2^BLINK_LOG2 complete frames.
HEX_MODE, 0, 1: codes A-F show hex glyphs; 0: codes >9 show a dash.

Ports:
Clk  in  1  system clock, rising edge.
Rst_n  in  1  asynchronous active-low reset.
En  in  1  1: scanning output enabled; 0: all anodes/segments off, counters keep running.
Load  in  1  1-cycle strobe that latches Bcd, Dp, Blink_mask, Blank_lz.
Bcd  in  4*N_DIGITS  packed digit codes; digit i = Bcd[4i+3:4i].
Dp  in  N_DIGITS  decimal-point request per digit.
Blink_mask  in  N_DIGITS  1: digit blinks.
Blank_lz  in  1  leading-zero suppression enable.
Seg  out  7  segments gfedcba, active-low.
Dp_n  out  1  decimal point, active-low.
An  out  N_DIGITS  digit enables, active-low, at most one low.

Behaviour:
- Reset (async, Rst_n=0):
  - latched data/flags = 0; scan counter = 0; digit index = 0; blink phase = 0
  - Seg = 7'h7F, Dp_n = 1, An = all ones, effective immediately
  - Release is synchronous to Clk.
- Load: latched regs update at the edge where Load=1. The new value is used from the next output register update; there is no other handshake. Load during a slot changes that slot's content mid-slot (acceptable).
- Scan counter: counts 0..SCAN_DIV-1. At terminal count:
  - counter wraps to 0
  - digit index advances (N_DIGITS-1 wraps to 0)
  - blank flag is set for exactly one cycle
- Frame counter: increments when the index wraps N_DIGITS-1 -> 0. The blink phase toggles when the frame counter's low BLINK_LOG2 bits wrap to 0.
- Outputs are all registered.
  - Each digit drives the pins for SCAN_DIV-1 cycles, followed by 1 all-off cycle (An all ones, Seg 7'h7F, Dp_n 1).
  - Pins lag the internal index by one cycle.
  - One frame = N_DIGITS*SCAN_DIV cycles.
- Digit i is dark (An bit high, Seg off, Dp_n 1) if any of:
  - En=0
  - the blanking cycle
  - Blink_mask[i] and blink phase = 1
  - leading-zero suppressed
- Leading-zero rule: with Blank_lz=1, digit i (i>0) is suppressed iff:
  - every digit j>=i has code 0, and
  - no Dp[j] is set for j>=i
  - Digit 0 is never suppressed.
- Decoding: codes 0-9 give standard glyphs, active-low. Codes 10-15 depend on HEX_MODE:
  - HEX_MODE=1: A b C d E F
  - HEX_MODE=0: dash, Seg = 7'b0111111
- Dp_n = ~Dp[i] while digit i is lit.

Decomposition:
- Package seg_pkg:
  - glyph constants SEG_0..SEG_F, SEG_DASH, SEG_OFF (7'h7F), all active-low gfedcba
  - function for the leading-zero mask
- Sub-module seg_decode: combinational, parameter HEX_MODE, 4-bit code -> 7-bit active-low segments. It is the single source of glyphs; the legacy single-digit decoder may later be replaced by it.

Test Plan:
(bench uses N_DIGITS=4, SCAN_DIV=4, BLINK_LOG2=1)
1. Pulse Rst_n low mid-slot while digit 2 is lit -> An=4'b1111, Seg=7'h7F in the same cycle. After release, the first lit slot is digit 0 with code 0 -> Seg=7'b1000000.
2. Load Bcd=16'h1234, Blank_lz=0 -> repeating pin sequence:
   - An=1110 Seg=0011001 for 3 cycles
   - 1 all-off cycle
   - An=1101 Seg=0110000
   - An=1011 Seg=0100100
   - An=0111 Seg=1111001
   - An is never two-hot.
3. Load Bcd=16'h0007, Blank_lz=1 -> An low only in digit 0's slot, Seg=1111000; digits 3..1 stay dark for the full frame.
4. Load Bcd=16'h0005, Dp=4'b0010, Blank_lz=1 -> digits 3,2 dark; digit 1 shows Seg=1000000 with Dp_n=0; digit 0 shows Seg=0010010 with Dp_n=1.
5. Load Bcd=16'h000A: HEX_MODE=0 -> digit 0 Seg=0111111; HEX_MODE=1 -> digit 0 Seg=0001000.
6. Load Blink_mask=4'b0001 -> digit 0 lit for 2 frames, dark for 2 frames, repeating; other digits unaffected. En=0 for one frame -> all dark throughout; the blink cadence stays aligned.
